// File: rtl/alu_mc_if.sv
// alu_mc handshake bundle: operand/op side and result/flag side.
// master drives operands and out_ready; slave is the ALU.
interface alu_mc_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [4:0]       aluc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] hi;
   logic             zero;
   logic             carry;
   logic             negative;
   logic             overflow;
   logic             err;

   modport master (
      output in_valid, a, b, aluc, out_ready,
      input  in_ready, out_valid, r, hi,
      input  zero, carry, negative, overflow, err
   );

   modport slave (
      input  in_valid, a, b, aluc, out_ready,
      output in_ready, out_valid, r, hi,
      output zero, carry, negative, overflow, err
   );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multicycle ALU, 16 legacy ops + iterative MULU/DIVU.
// Define ALU_MC_DIV_EN to build the divider; otherwise DIVU is illegal.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input logic   clk,
   input logic   rst_n,
   alu_mc_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t st, nxt;

   logic             acc, rdy, last;
   logic             is_mul, is_div;
   logic [SHW-1:0]   cnt, sh, shl_idx, shr_idx;
   logic [WIDTH-1:0] a, b;
   logic [WIDTH-1:0] opnd, wk_hi, wk_lo;
   logic [WIDTH:0]   add_s, sub_s, mul_s;
   logic [WIDTH-1:0] lr, mhi_n, mlo_n;
   logic             lz, lc, ln, lv;
   logic [WIDTH-1:0] r_q, hi_q;
   logic             z_q, c_q, n_q, v_q, e_q;

   assign a  = bus.a;
   assign b  = bus.b;
   assign sh = a[SHW-1:0];

   assign is_mul = (bus.aluc == 5'b10000);
`ifdef ALU_MC_DIV_EN
   assign is_div = (bus.aluc == 5'b10001);
`else
   assign is_div = 1'b0;
`endif

   assign rdy  = rst_n & ((st == IDLE) | ((st == DONE) & bus.out_ready));
   assign acc  = bus.in_valid & rdy;
   assign last = (cnt == SHW'(WIDTH - 1));

   // single-cycle result and flags for the legacy 4-bit op codes
   always_comb begin
      add_s   = {1'b0, a} + {1'b0, b};
      sub_s   = {1'b0, a} - {1'b0, b};
      shr_idx = sh - 1'b1;
      shl_idx = ~sh + 1'b1;
      lr = '0;
      lc = 1'b0;
      lv = 1'b0;
      unique case (bus.aluc[3:0])
         4'b0000: begin
            lr = add_s[WIDTH-1:0];
            lc = add_s[WIDTH];
         end
         4'b0001: begin
            lr = sub_s[WIDTH-1:0];
            lc = sub_s[WIDTH];
         end
         4'b0010: begin
            lr = add_s[WIDTH-1:0];
            lv = (a[WIDTH-1] == b[WIDTH-1]) &&
                 (lr[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0011: begin
            lr = sub_s[WIDTH-1:0];
            lv = (a[WIDTH-1] != b[WIDTH-1]) &&
                 (lr[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0100: lr = a & b;
         4'b0101: lr = a | b;
         4'b0110: lr = a ^ b;
         4'b0111: lr = ~(a | b);
         4'b1000, 4'b1001:
            lr = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         4'b1010: begin
            lr = {{(WIDTH-1){1'b0}}, (a < b)};
            lc = (a < b);
         end
         4'b1011:
            lr = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         4'b1100: begin
            lr = $signed(b) >>> sh;
            lc = (sh != '0) & b[shr_idx];
         end
         4'b1101: begin
            lr = b >> sh;
            lc = (sh != '0) & b[shr_idx];
         end
         default: begin
            lr = b << sh;
            lc = (sh != '0) & b[shl_idx];
         end
      endcase
      lz = (lr == '0);
      ln = lr[WIDTH-1];
      if (bus.aluc[3:1] == 3'b101) begin
         lz = (a == b);
         ln = bus.aluc[0] & lr[0];
      end
   end

   // one shift-add multiply step: hi:lo shifts right, multiplier in lo
   always_comb begin
      mul_s = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, opnd} : '0);
      mhi_n = mul_s[WIDTH:1];
      mlo_n = {mul_s[0], wk_lo[WIDTH-1:1]};
   end

`ifdef ALU_MC_DIV_EN
   logic [WIDTH:0]   dt, dd;
   logic             dge;
   logic [WIDTH-1:0] dhi_n, dlo_n;

   // one restoring divide step: remainder in hi, quotient shifts into lo
   always_comb begin
      dt    = {wk_hi, wk_lo[WIDTH-1]};
      dd    = dt - {1'b0, opnd};
      dge   = (dt >= {1'b0, opnd});
      dhi_n = dge ? dd[WIDTH-1:0] : dt[WIDTH-1:0];
      dlo_n = {wk_lo[WIDTH-2:0], dge};
   end
`endif

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) st <= IDLE;
      else        st <= nxt;
   end

   // next state
   always_comb begin
      nxt = st;
      if (((st == MUL) || (st == DIV)) && last)
         nxt = DONE;
      if (acc)
         nxt = is_mul ? MUL : (is_div ? DIV : DONE);
      else if ((st == DONE) && bus.out_ready)
         nxt = IDLE;
   end

   // operand capture, iteration registers and registered result/flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt   <= '0;
         opnd  <= '0;
         wk_hi <= '0;
         wk_lo <= '0;
         r_q   <= '0;
         hi_q  <= '0;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
         n_q   <= 1'b0;
         v_q   <= 1'b0;
         e_q   <= 1'b0;
      end else if (acc) begin
         cnt   <= '0;
         opnd  <= is_mul ? a : b;
         wk_lo <= is_mul ? b : a;
         wk_hi <= '0;
         if (!bus.aluc[4]) begin
            r_q  <= lr;
            hi_q <= '0;
            z_q  <= lz;
            c_q  <= lc;
            n_q  <= ln;
            v_q  <= lv;
            e_q  <= 1'b0;
         end else if (!is_mul && !is_div) begin
            r_q  <= '0;
            hi_q <= '0;
            z_q  <= 1'b0;
            c_q  <= 1'b0;
            n_q  <= 1'b0;
            v_q  <= 1'b0;
            e_q  <= 1'b1;
         end
      end else if (st == MUL) begin
         cnt   <= cnt + 1'b1;
         wk_hi <= mhi_n;
         wk_lo <= mlo_n;
         if (last) begin
            r_q  <= mlo_n;
            hi_q <= mhi_n;
            z_q  <= (mlo_n == '0);
            c_q  <= (mhi_n != '0);
            n_q  <= mlo_n[WIDTH-1];
            v_q  <= 1'b0;
            e_q  <= 1'b0;
         end
`ifdef ALU_MC_DIV_EN
      end else if (st == DIV) begin
         cnt   <= cnt + 1'b1;
         wk_hi <= dhi_n;
         wk_lo <= dlo_n;
         if (last) begin
            r_q  <= dlo_n;
            hi_q <= dhi_n;
            z_q  <= (dlo_n == '0);
            c_q  <= 1'b0;
            n_q  <= dlo_n[WIDTH-1];
            v_q  <= (opnd == '0);
            e_q  <= 1'b0;
         end
`endif
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = (st == DONE);
   assign bus.r         = r_q;
   assign bus.hi        = hi_q;
   assign bus.zero      = z_q;
   assign bus.carry     = c_q;
   assign bus.negative  = n_q;
   assign bus.overflow  = v_q;
   assign bus.err       = e_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vector table plus hand sequences for
// hold, back-to-back, operand change during MULU and reset abort.
module tb_alu_mc;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   alu_mc_if #(.WIDTH(W)) bus ();

   alu_mc #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic [W-1:0] hi;
      logic [4:0]   f;
      int           lat;
   } vec_t;

   vec_t vq[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [4:0] flags();
      return {bus.zero, bus.carry, bus.negative, bus.overflow, bus.err};
   endfunction

   function automatic void addv(input logic [4:0] op,
                                input logic [W-1:0] a, b, r, hi,
                                input logic [4:0] f, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.r = r; v.hi = hi;
      v.f = f; v.lat = lat;
      vq.push_back(v);
   endfunction

   task automatic send(input logic [4:0] op, input logic [W-1:0] a, b);
      @(negedge clk);
      bus.aluc = op;
      bus.a = a;
      bus.b = b;
      bus.in_valid = 1'b1;
      chk("in_ready_at_accept", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat, output bit busy);
      lat = 1;
      busy = 1'b0;
      while (!bus.out_valid && lat < 200) begin
         if (bus.in_ready) busy = 1'b1;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bit busy, bad;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.aluc = '0;
      bus.out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_r", bus.r, 0);
      chk("rst_hi", bus.hi, 0);
      chk("rst_flags", flags(), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // flags = {zero, carry, negative, overflow, err}
      addv(5'b00010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 5'b00110, 1);
      addv(5'b00001, 32'h3, 32'h5, 32'hFFFFFFFE, 0, 5'b01100, 1);
      addv(5'b00001, 32'h5, 32'h5, 32'h0, 0, 5'b10000, 1);
      addv(5'b01011, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 5'b00100, 1);
      addv(5'b01011, 32'h1, 32'hFFFFFFFF, 32'h0, 0, 5'b00000, 1);
      addv(5'b01100, 32'h4, 32'h80000010, 32'hF8000001, 0, 5'b00100, 1);
      addv(5'b01100, 32'h1F, 32'h80000000, 32'hFFFFFFFF, 0, 5'b00100, 1);
      addv(5'b01110, 32'h1, 32'h80000000, 32'h0, 0, 5'b11000, 1);
      addv(5'b01111, 32'h4, 32'hF000000F, 32'h000000F0, 0, 5'b01000, 1);
      addv(5'b00000, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 5'b11000, 1);
      addv(5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0,
           5'b00100, 1);
      addv(5'b00101, 32'h1, 32'h2, 32'h3, 0, 5'b00000, 1);
      addv(5'b00110, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0, 0, 5'b10000, 1);
      addv(5'b00111, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 5'b00100, 1);
      addv(5'b01001, 32'h0, 32'h00001234, 32'h12340000, 0, 5'b00000, 1);
      addv(5'b01010, 32'h1, 32'h2, 32'h1, 0, 5'b01000, 1);
      addv(5'b01010, 32'h5, 32'h5, 32'h0, 0, 5'b10000, 1);
      addv(5'b01101, 32'h0, 32'h80000001, 32'h80000001, 0, 5'b00100, 1);
      addv(5'b01101, 32'h1, 32'h3, 32'h1, 0, 5'b01000, 1);
      addv(5'b00011, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 5'b00010, 1);
      addv(5'b10010, 32'h12, 32'h34, 32'h0, 0, 5'b00001, 1);
      addv(5'b11111, 32'h12, 32'h34, 32'h0, 0, 5'b00001, 1);
      addv(5'b10000, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h1, 5'b01100, 33);
      addv(5'b10000, 32'h0, 32'h5, 32'h0, 32'h0, 5'b10000, 33);
      addv(5'b10000, 32'h12345678, 32'h10, 32'h23456780, 32'h1,
           5'b01000, 33);
`ifdef ALU_MC_DIV_EN
      addv(5'b10001, 32'h64, 32'h0, 32'hFFFFFFFF, 32'h64, 5'b00110, 33);
      addv(5'b10001, 32'd100, 32'd7, 32'd14, 32'd2, 5'b00000, 33);
`else
      addv(5'b10001, 32'h64, 32'h0, 32'h0, 32'h0, 5'b00001, 1);
`endif

      foreach (vq[i]) begin
         send(vq[i].op, vq[i].a, vq[i].b);
         wait_out(lat, busy);
         chk($sformatf("v%0d_lat", i), lat, vq[i].lat);
         chk($sformatf("v%0d_r", i), bus.r, vq[i].r);
         chk($sformatf("v%0d_hi", i), bus.hi, vq[i].hi);
         chk($sformatf("v%0d_flags", i), flags(), vq[i].f);
         chk($sformatf("v%0d_busy_ready", i), busy, 0);
         @(posedge clk);
         #1;
      end

      // result held while the consumer stalls
      bus.out_ready = 1'b0;
      send(5'b00010, 32'h7FFFFFFF, 32'h1);
      wait_out(lat, busy);
      chk("hold_lat", lat, 1);
      bad = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (!bus.out_valid || bus.in_ready || bus.r !== 32'h80000000 ||
             bus.hi !== 32'h0 || flags() !== 5'b00110)
            bad = 1'b1;
      end
      chk("hold_stable", bad, 0);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_release_idle", bus.out_valid, 0);

      // back-to-back single-cycle ops
      @(negedge clk);
      bus.aluc = 5'b00000;
      bus.a = 32'h2;
      bus.b = 32'h3;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("b2b_v1", bus.out_valid, 1);
      chk("b2b_r1", bus.r, 32'h5);
      chk("b2b_ready", bus.in_ready, 1);
      bus.aluc = 5'b00110;
      bus.a = 32'hF;
      bus.b = 32'h1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("b2b_v2", bus.out_valid, 1);
      chk("b2b_r2", bus.r, 32'hE);
      @(posedge clk);
      #1;
      chk("b2b_idle", bus.out_valid, 0);

      // operands may change while MULU iterates
      send(5'b10000, 32'h3, 32'h5);
      bus.a = $urandom;
      bus.b = $urandom;
      bus.aluc = 5'b00000;
      wait_out(lat, busy);
      chk("mulchg_lat", lat, 33);
      chk("mulchg_r", bus.r, 32'd15);
      chk("mulchg_hi", bus.hi, 0);
      @(posedge clk);
      #1;

      // reset aborts MULU in flight
      send(5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_in_ready", bus.in_ready, 0);
      chk("abort_r", bus.r, 0);
      chk("abort_hi", bus.hi, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) bad = 1'b1;
      end
      chk("abort_no_stale", bad, 0);
      send(5'b00000, 32'h2, 32'h3);
      wait_out(lat, busy);
      chk("post_abort_lat", lat, 1);
      chk("post_abort_r", bus.r, 32'h5);
      @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
